mem_dump_sequencer: RTL and testbench

Initiator side of the control unit's inference read port. After the processor finishes, it walks a contiguous range of data-memory addresses, drives `infer`/`infer_addr`, and captures `infer_data` after a fixed read latency. Each word goes to the board output path (LEDs or seven-segment) through a valid/ready handshake. It sits between the top-level debug controls and the control unit, and replaces manual address entry on the switches.

---
 rtl/mem_dump_pkg.sv | 23 ++
 rtl/read_latency_timer.sv | 38 +++
 rtl/mem_dump_sequencer.sv | 127 ++++++++++++
 tb/tb_mem_dump_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// ---------------------------------------------------------------------------
// mem_dump_pkg
// Shared constants for the memory dump sequencer: default parameter values,
// latency-counter width and the FSM state encoding.
// ---------------------------------------------------------------------------
package mem_dump_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int READ_LAT_DEF = 2;

    // Latency counter is 4 bits wide, which covers READ_LAT up to 15.
    localparam int LAT_W = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_PRESENT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/read_latency_timer.sv
// ---------------------------------------------------------------------------
// read_latency_timer
// Loadable down-counter with a zero flag. Loaded while the sequencer issues
// a read, counted down while it waits for read data.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load cnt with load_val (has priority over en)
//   load_val    value to load
//   en          decrement by one when nonzero
//   zero        cnt == 0
// ---------------------------------------------------------------------------
module read_latency_timer
    import mem_dump_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_dump_sequencer.sv
// ---------------------------------------------------------------------------
// mem_dump_sequencer
// Walks a contiguous range of data-memory addresses through the control
// unit's inference read port and presents each word on a valid/ready
// output towards the board display path.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a dump (only looked at while idle)
//   base_addr, count  first address and word count, latched on start
//   infer, infer_addr inference request / read address to control unit
//   infer_data        read data from control unit (READ_LAT cycles later)
//   out_data/out_addr captured word and its address
//   out_valid/ready   output handshake
//   busy              high whenever not idle
//   done              one-cycle pulse at the end of a dump
//   checksum          (only with MEM_DUMP_CHECKSUM_EN) running modular sum
//                     of every transferred word, cleared on start
//
// Build option: define MEM_DUMP_CHECKSUM_EN to add the checksum output.
// ---------------------------------------------------------------------------
module mem_dump_sequencer
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              infer,
    output logic [ADDR_W-1:0] infer_addr,
    input  logic [DATA_W-1:0] infer_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // ISSUE loads READ_LAT-1 and WAIT spends READ_LAT cycles counting to 0,
    // so data is sampled READ_LAT cycles after the address went out.
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic              lat_zero;
    logic              xfer;

    assign xfer = (state == ST_PRESENT) && out_ready;

    read_latency_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_ISSUE),
        .load_val (LAT_INIT),
        .en       (state == ST_WAIT),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= count;
                        state     <= (count != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (lat_zero) begin
                        out_data <= infer_data;
                        out_addr <= cur_addr;
                        state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        remaining <= remaining - ADDR_W'(1);
                        cur_addr  <= cur_addr + ADDR_W'(1);  // wraps naturally
                        state     <= (remaining == ADDR_W'(1)) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + out_data;
        end
    end
`endif

    // The address register feeds the read port directly; it is stable for
    // the whole ISSUE/WAIT/PRESENT span of each word.
    assign infer_addr = cur_addr;
    assign infer      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_PRESENT);
    assign out_valid  = (state == ST_PRESENT);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_sequencer
// Directed bench for mem_dump_sequencer with READ_LAT=2. A two-stage model
// memory returns addr*3 (or a fixed table at 0x100..0x102).
// ---------------------------------------------------------------------------
module tb_mem_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] count = '0;
    logic        infer;
    logic [15:0] infer_addr;
    logic [31:0] infer_data;
    logic [31:0] out_data;
    logic [15:0] out_addr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int tests = 0;
    int fails = 0;

    mem_dump_sequencer #(.ADDR_W(16), .DATA_W(32), .READ_LAT(2)) dut (
`ifdef MEM_DUMP_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .infer      (infer),
        .infer_addr (infer_addr),
        .infer_data (infer_data),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        case (a)
            16'h0100: mem_f = 32'd5;
            16'h0101: mem_f = 32'd7;
            16'h0102: mem_f = 32'hFFFF_FFFF;
            default:  mem_f = {16'h0, a} * 32'd3;
        endcase
    endfunction

    // Data for an address appears two edges after the address settles.
    logic [31:0] mp0, mp1;
    always @(posedge clk) begin
        mp0 <= mem_f(infer_addr);
        mp1 <= mp0;
    end
    assign infer_data = mp1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          ndone, done_at;
    logic        saw_infer, busy_after;

    // Samples one cycle per iteration, recording transfers (index i means the
    // transfer happens at the edge after sample i), until one sample past done.
    task automatic collect(input int max);
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        ndone = 0; done_at = -1; saw_infer = 1'b0; busy_after = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (infer) saw_infer = 1'b1;
            if (out_valid && out_ready) begin
                q_addr.push_back(out_addr);
                q_data.push_back(out_data);
                q_cyc.push_back(i);
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (done_at >= 0 && i == done_at + 1) begin
                busy_after = busy;
                break;
            end
            tick();
        end
    endtask

    int nd;

    initial begin
        // reset state
        #2;
        chk("rst_infer",     infer, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_done",      done, 0);
        chk("rst_valid",     out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_addr",  out_addr, 0);
        chk("rst_infer_adr", infer_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic dump
        out_ready = 1'b1;
        do_start(16'h1000, 16'd3);
        chk("b_infer_issue", infer, 1);
        chk("b_addr_issue",  infer_addr, 16'h1000);
        collect(60);
        chk("b_nwords", q_addr.size(), 3);
        chk("b_addr0", q_addr[0], 16'h1000);
        chk("b_addr1", q_addr[1], 16'h1001);
        chk("b_addr2", q_addr[2], 16'h1002);
        chk("b_data0", q_data[0], 32'h3000);
        chk("b_data1", q_data[1], 32'h3003);
        chk("b_data2", q_data[2], 32'h3006);
        chk("b_cyc0",  q_cyc[0], 3);
        chk("b_cyc1",  q_cyc[1], 7);
        chk("b_cyc2",  q_cyc[2], 11);
        chk("b_ndone", ndone, 1);
        chk("b_done_at", done_at, 12);
        chk("b_busy_after", busy_after, 0);

        // backpressure on word 1
        out_ready = 1'b0;
        do_start(16'h0040, 16'd2);
        tick(); tick(); tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data, 32'hC0);
            chk("bp_addr",  out_addr, 16'h0040);
            chk("bp_iaddr", infer_addr, 16'h0040);
            tick();
        end
        out_ready = 1'b1;
        collect(40);
        chk("bp_nwords", q_addr.size(), 2);
        chk("bp_addr0", q_addr[0], 16'h0040);
        chk("bp_cyc0",  q_cyc[0], 0);
        chk("bp_addr1", q_addr[1], 16'h0041);
        chk("bp_data1", q_data[1], 32'hC3);
        chk("bp_cyc1",  q_cyc[1], 4);
        chk("bp_ndone", ndone, 1);

        // address wrap
        do_start(16'hFFFF, 16'd2);
        collect(40);
        chk("w_nwords", q_addr.size(), 2);
        chk("w_addr0", q_addr[0], 16'hFFFF);
        chk("w_data0", q_data[0], 32'h0002_FFFD);
        chk("w_addr1", q_addr[1], 16'h0000);
        chk("w_data1", q_data[1], 32'h0);

        // zero count
        do_start(16'h1234, 16'd0);
        collect(10);
        chk("z_nwords", q_addr.size(), 0);
        chk("z_done_at", done_at, 0);
        chk("z_ndone", ndone, 1);
        chk("z_infer", saw_infer, 0);
        chk("z_busy_after", busy_after, 0);

        // start while busy is ignored
        do_start(16'h1000, 16'd3);
        tick();
        base_addr = 16'h2000;
        count     = 16'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        collect(60);
        chk("sb_nwords", q_addr.size(), 3);
        chk("sb_addr0", q_addr[0], 16'h1000);
        chk("sb_addr2", q_addr[2], 16'h1002);
        chk("sb_ndone", ndone, 1);

`ifdef MEM_DUMP_CHECKSUM_EN
        do_start(16'h0100, 16'd3);
        chk("cs_clear", checksum, 0);
        collect(60);
        chk("cs_final", checksum, 32'h0000_000B);
        tick();
        chk("cs_hold", checksum, 32'h0000_000B);
`endif

        // reset during WAIT of word 2
        do_start(16'h0010, 16'd3);
        repeat (5) tick();
        chk("r_pre_infer", infer, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_infer", infer, 0);
        chk("r_busy",  busy, 0);
        chk("r_valid", out_valid, 0);
        chk("r_data",  out_data, 0);
        chk("r_addr",  out_addr, 0);
        chk("r_iaddr", infer_addr, 0);
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) nd++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) nd++;
        end
        chk("r_no_done", nd, 0);
        chk("r_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
